// File: rtl/lcd_multi_ch_ctrl.sv
// HD44780 8-bit write-only driver: init, then a snapshot/BCD/refresh frame loop.
// Ports: clk, reset (async active-low), vals, hold -> rs, rw, enable, data, init_done, frame_done.
// Optional: define LCD_LZ_BLANK_EN to blank leading integer zeros.
module lcd_multi_ch_ctrl #(
  parameter int N_CH      = 3,
  parameter int VAL_W     = 16,
  parameter int DIGITS    = 3,
  parameter int TICK_DIV  = 100000,
  parameter int PWR_TICKS = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*VAL_W-1:0] vals,
  input  logic                  hold,
  output logic                  rs,
  output logic                  rw,
  output logic                  enable,
  output logic [7:0]            data,
  output logic                  init_done,
  output logic                  frame_done
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int PW = $clog2(PWR_TICKS + 1);
  localparam int CW = $clog2(VAL_W + 1);
  localparam int BW = 4 * DIGITS;
  localparam int XW = VAL_W + 14;
  localparam logic [XW-1:0] LIM = XW'(10 ** DIGITS);

  if (N_CH < 1 || N_CH > 4 || DIGITS < 2 || DIGITS > 4 ||
      TICK_DIV <= VAL_W + 8) begin : g_bad_param
    $error("lcd_multi_ch_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, LATCH, CONV, ADDR, LABEL, VALUE
  } state_t;

  state_t                      state_q, state_d;
  logic [TW-1:0]               tcnt_q, tcnt_d;
  logic [PW-1:0]               pcnt_q, pcnt_d;
  logic [1:0]                  ph_q, ph_d;
  logic [2:0]                  idx_q, idx_d;
  logic [1:0]                  k_q, k_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [BW-1:0]               acc_q, acc_d;
  logic [VAL_W-1:0]            sh_q, sh_d;
  logic [N_CH*VAL_W-1:0]       snap_q, snap_d;
  logic [N_CH-1:0][BW-1:0]     bcd_q, bcd_d;
  logic [N_CH-1:0]             ovf_q, ovf_d;
  logic                        rs_q, rs_d;
  logic                        en_q, en_d;
  logic [7:0]                  data_q, data_d;
  logic                        init_q, init_d;
  logic                        fd_q, fd_d;

  logic             tick;
  logic [VAL_W-1:0] snap_k;
  logic [BW-1:0]    bcd_k;
  logic             cur_rs;
  logic [7:0]       cur_byte;
  logic [BW-1:0]    adj;
  logic [VAL_W-1:0] src;
  logic             last;

  assign tick   = (tcnt_q == TW'(TICK_DIV - 1));
  assign snap_k = snap_q[k_q*VAL_W +: VAL_W];
  assign bcd_k  = bcd_q[k_q];

  // Byte presented by the current send state and position.
  always_comb begin
    int         pos;
    logic [3:0] dig;
    logic       blank;
`ifdef LCD_LZ_BLANK_EN
    logic       lead;
`endif
    cur_rs   = 1'b0;
    cur_byte = 8'h00;
    pos      = (int'(idx_q) == DIGITS) ? DIGITS - 1 : int'(idx_q);
    dig      = 4'(bcd_k >> (4 * (DIGITS - 1 - pos)));
`ifdef LCD_LZ_BLANK_EN
    lead = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (i <= pos && bcd_k[4*(DIGITS-1-i) +: 4] != 4'd0) lead = 1'b0;
    blank = lead && (pos < DIGITS - 2);
`else
    blank = 1'b0;
`endif
    unique case (state_q)
      INIT: begin
        unique case (idx_q)
          3'd3:    cur_byte = 8'h0C;
          3'd4:    cur_byte = 8'h01;
          3'd5:    cur_byte = 8'h06;
          default: cur_byte = 8'h38;
        endcase
      end
      ADDR: cur_byte = {1'b1, k_q[1], 2'b00, k_q[0], 3'b000};
      LABEL: begin
        cur_rs = 1'b1;
        unique case (idx_q)
          3'd0:    cur_byte = 8'h53;
          3'd1:    cur_byte = 8'h31 + {6'b0, k_q};
          default: cur_byte = 8'h3A;
        endcase
      end
      VALUE: begin
        cur_rs = 1'b1;
        if (int'(idx_q) == DIGITS - 1) cur_byte = 8'h2E;
        else if (ovf_q[k_q])           cur_byte = 8'h2D;
        else if (blank)                cur_byte = 8'h20;
        else                           cur_byte = {4'h3, dig};
      end
      default: ;
    endcase
  end

  // Double-dabble step; dropping the top carry yields the value mod 10^DIGITS,
  // which is all that is shown since larger values display as dashes.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++)
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    src = (cnt_q == '0) ? snap_k : sh_q;
  end

  always_comb begin
    state_d = state_q;
    tcnt_d  = tick ? '0 : tcnt_q + 1'b1;
    pcnt_d  = pcnt_q;
    ph_d    = ph_q;
    idx_d   = idx_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    snap_d  = snap_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    rs_d    = rs_q;
    en_d    = en_q;
    data_d  = data_q;
    init_d  = init_q;
    fd_d    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      PWR_WAIT: begin
        if (tick) begin
          if (pcnt_q == PW'(PWR_TICKS - 1)) begin
            pcnt_d  = '0;
            state_d = INIT;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
      LATCH: begin
        if (!hold) snap_d = vals;
        k_d     = '0;
        cnt_d   = '0;
        acc_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        if (cnt_q == CW'(VAL_W)) begin
          bcd_d[k_q] = acc_q;
          ovf_d[k_q] = {{(XW-VAL_W){1'b0}}, snap_k} >= LIM;
          ph_d       = '0;
          idx_d      = '0;
          state_d    = ADDR;
        end else begin
          acc_d = {adj[BW-2:0], src[VAL_W-1]};
          sh_d  = src << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (tick) begin
          unique case (ph_q)
            2'd0: begin
              rs_d   = cur_rs;
              data_d = cur_byte;
              en_d   = 1'b0;
              ph_d   = 2'd1;
            end
            2'd1: begin
              en_d = 1'b1;
              ph_d = 2'd2;
            end
            default: begin
              en_d  = 1'b0;
              ph_d  = 2'd0;
              idx_d = idx_q + 1'b1;
              last  = 1'b1;
            end
          endcase
        end
        if (last) begin
          unique case (state_q)
            INIT: if (idx_q == 3'd5) begin
              idx_d   = '0;
              init_d  = 1'b1;
              state_d = LATCH;
            end
            ADDR: begin
              idx_d   = '0;
              state_d = LABEL;
            end
            LABEL: if (idx_q == 3'd2) begin
              idx_d   = '0;
              state_d = VALUE;
            end
            VALUE: if (idx_q == 3'(DIGITS)) begin
              idx_d = '0;
              if (k_q == 2'(N_CH - 1)) begin
                fd_d    = 1'b1;
                state_d = LATCH;
              end else begin
                k_d     = k_q + 1'b1;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = CONV;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PWR_WAIT;
      tcnt_q  <= '0;
      pcnt_q  <= '0;
      ph_q    <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      snap_q  <= '0;
      bcd_q   <= '0;
      ovf_q   <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      init_q  <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      pcnt_q  <= pcnt_d;
      ph_q    <= ph_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      snap_q  <= snap_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      data_q  <= data_d;
      init_q  <= init_d;
      fd_q    <= fd_d;
    end
  end

  assign rs         = rs_q;
  assign rw         = 1'b0;
  assign enable     = en_q;
  assign data       = data_q;
  assign init_done  = init_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_multi_ch_ctrl.sv
// Testbench for lcd_multi_ch_ctrl: byte stream on rising E vs a formatting model.
// Covers power-up, frame content, overflow, snapshot/hold, reset mid-frame, zero blanking.
module tb_lcd_multi_ch_ctrl;

  localparam int N_CH      = 3;
  localparam int VAL_W     = 16;
  localparam int DIGITS    = 3;
  localparam int TICK_DIV  = 8;
  localparam int PWR_TICKS = 2;
  localparam int FRAME_TICKS = 3 * N_CH * (DIGITS + 5);
`ifdef LCD_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  hold = 1'b0;
  logic [N_CH*VAL_W-1:0] vals = '0;
  logic                  rs, rw, enable, init_done, frame_done;
  logic [7:0]            data;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [8:0] bq[$];
  logic [8:0] exp_q[$];
  logic       en_prev = 1'b0;
  int         fd_cnt = 0;
  int         cyc = 0;
  int         fd_last = 0;
  int         fd_prev = 0;
  logic       rw_seen = 1'b0;

  lcd_multi_ch_ctrl #(
    .N_CH(N_CH), .VAL_W(VAL_W), .DIGITS(DIGITS),
    .TICK_DIV(TICK_DIV), .PWR_TICKS(PWR_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .vals(vals), .hold(hold),
    .rs(rs), .rw(rw), .enable(enable), .data(data),
    .init_done(init_done), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (enable && !en_prev) bq.push_back({rs, data});
    en_prev <= enable;
    if (rw) rw_seen <= 1'b1;
    if (frame_done) begin
      fd_cnt  <= fd_cnt + 1;
      fd_prev <= fd_last;
      fd_last <= cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic set_vals(input int unsigned v[N_CH]);
    for (int k = 0; k < N_CH; k++) vals[k*VAL_W +: VAL_W] = VAL_W'(v[k]);
  endtask

  // Expected frame: address, label, then the formatted fixed-point field.
  task automatic build_exp(input int unsigned v[N_CH]);
    int unsigned p;
    bit b;
    exp_q.delete();
    for (int k = 0; k < N_CH; k++) begin
      exp_q.push_back({1'b0, 8'(128 + 64 * (k / 2) + 8 * (k % 2))});
      exp_q.push_back({1'b1, 8'h53});
      exp_q.push_back({1'b1, 8'(49 + k)});
      exp_q.push_back({1'b1, 8'h3A});
      if (v[k] >= 10 ** DIGITS) begin
        for (int j = 0; j < DIGITS - 1; j++) exp_q.push_back({1'b1, 8'h2D});
        exp_q.push_back({1'b1, 8'h2E});
        exp_q.push_back({1'b1, 8'h2D});
      end else begin
        for (int j = 0; j < DIGITS - 1; j++) begin
          p = 10 ** (DIGITS - 1 - j);
          b = LZ && (j < DIGITS - 2) && (v[k] / p == 0);
          exp_q.push_back({1'b1, b ? 8'h20 : 8'(48 + (v[k] / p) % 10)});
        end
        exp_q.push_back({1'b1, 8'h2E});
        exp_q.push_back({1'b1, 8'(48 + v[k] % 10)});
      end
    end
  endtask

  task automatic check_frame(input string name);
    int bad = -1;
    logic [8:0] g, e;
    n_tests++;
    for (int i = 0; i < exp_q.size() || i < bq.size(); i++) begin
      g = (i < bq.size()) ? bq[i] : 9'h1ff;
      e = (i < exp_q.size()) ? exp_q[i] : 9'h1ff;
      if (bad < 0 && g !== e) bad = i;
    end
    if (bad >= 0) begin
      g = (bad < bq.size()) ? bq[bad] : 9'h1ff;
      e = (bad < exp_q.size()) ? exp_q[bad] : 9'h1ff;
      n_fail++;
      $display("FAIL %s: byte %0d {rs,data} got %h expected %h (%0d of %0d bytes)",
               name, bad, g, e, bq.size(), exp_q.size());
    end
  endtask

  task automatic wait_fd(output bit ok);
    int c = fd_cnt;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (fd_cnt != c) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_done_timeout: no pulse within 3000 clocks");
    end
  endtask

  task automatic grab_frame();
    bit ok;
    wait_fd(ok);
    bq.delete();
    if (ok) wait_fd(ok);
  endtask

  task automatic power_up(input string name);
    int n = 0;
    @(negedge clk);
    reset = 1'b1;
    bq.delete();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (enable) break;
    end
    n_tests++;
    if (n !== (PWR_TICKS + 2) * TICK_DIV) begin
      n_fail++;
      $display("FAIL %s_first_e: clocks %0d expected %0d", name, n,
               (PWR_TICKS + 2) * TICK_DIV);
    end
    for (int i = 0; i < 400 && bq.size() < 6; i++) begin
      @(posedge clk);
      #2;
    end
    n_tests++;
    if (init_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_init_early: init_done %b expected 0", name, init_done);
    end
    exp_q = '{9'h038, 9'h038, 9'h038, 9'h00C, 9'h001, 9'h006};
    check_frame({name, "_init_bytes"});
    for (int i = 0; i < 4 * TICK_DIV && init_done !== 1'b1; i++) @(posedge clk);
    #1;
    n_tests++;
    if (init_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_init_done: got %b expected 1", name, init_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rs, rw, enable, data, init_done, frame_done} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0000",
               {rs, rw, enable, data, init_done, frame_done});
    end
    power_up("powerup");
  endtask

  task automatic test_frame();
    int unsigned v[N_CH] = '{123, 7, 999};
    int per;
    set_vals(v);
    grab_frame();
    build_exp(v);
    check_frame("frame_content");
    per = fd_last - fd_prev;
    n_tests++;
    if (per < FRAME_TICKS * TICK_DIV ||
        per > FRAME_TICKS * TICK_DIV + N_CH * (VAL_W + 2 + TICK_DIV)) begin
      n_fail++;
      $display("FAIL frame_period: got %0d clocks expected %0d..%0d", per,
               FRAME_TICKS * TICK_DIV,
               FRAME_TICKS * TICK_DIV + N_CH * (VAL_W + 2 + TICK_DIV));
    end
  endtask

  task automatic test_overflow();
    int unsigned v[N_CH] = '{1000, 0, 65535};
    set_vals(v);
    grab_frame();
    build_exp(v);
    check_frame("overflow");
    v[0] = 999;
    set_vals(v);
    grab_frame();
    build_exp(v);
    check_frame("overflow_clear");
  endtask

  task automatic test_mid_frame();
    int unsigned a[N_CH] = '{42, 314, 88};
    int unsigned b[N_CH] = '{42, 271, 88};
    bit ok;
    set_vals(a);
    grab_frame();
    wait_fd(ok);
    bq.delete();
    repeat (200) @(posedge clk);
    set_vals(b);
    wait_fd(ok);
    build_exp(a);
    check_frame("mid_frame_old");
    bq.delete();
    wait_fd(ok);
    build_exp(b);
    check_frame("mid_frame_new");
  endtask

  task automatic test_hold();
    int unsigned b[N_CH] = '{42, 271, 88};
    int unsigned c[N_CH] = '{555, 1, 20};
    bit ok;
    hold = 1'b1;
    wait_fd(ok);
    set_vals(c);
    grab_frame();
    build_exp(b);
    check_frame("hold_frame1");
    bq.delete();
    wait_fd(ok);
    build_exp(b);
    check_frame("hold_frame2");
    hold = 1'b0;
    grab_frame();
    build_exp(c);
    check_frame("hold_release");
  endtask

  task automatic test_random();
    int unsigned v[N_CH];
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N_CH; k++)
        v[k] = ($urandom % 4 == 0) ? $urandom_range(0, 65535)
                                   : $urandom_range(0, 1100);
      set_vals(v);
      grab_frame();
      build_exp(v);
      check_frame($sformatf("random_%0d", r));
    end
  endtask

  task automatic test_lz();
    int unsigned v[N_CH] = '{5, 50, 0};
    logic [31:0] got, want;
    set_vals(v);
    grab_frame();
    build_exp(v);
    check_frame("lz_frame");
`ifdef LCD_LZ_BLANK_EN
    want = 32'h20302E35;
`else
    want = 32'h30302E35;
`endif
    got = (bq.size() >= 8) ? {bq[4][7:0], bq[5][7:0], bq[6][7:0], bq[7][7:0]}
                           : 32'hFFFFFFFF;
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL lz_value5: got %h expected %h", got, want);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_fd(ok);
    bq.delete();
    for (int i = 0; i < 1000 && bq.size() < 5; i++) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({enable, data, init_done} !== 10'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async: {en,data,init} got %h expected 000",
               {enable, data, init_done});
    end
    repeat (3) @(posedge clk);
    power_up("reinit");
    n_tests++;
    if (rw_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rw_low: rw seen %b expected 0", rw_seen);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overflow();
    test_mid_frame();
    test_hold();
    test_random();
    test_lz();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
